vga_timing_rx: RTL
==================

// Module: vga_timing_rx
// PURPOSE
//  Receive-side counterpart of the VGA/SXGA timing generator. Samples incoming hsync/vsync/de
//  on the pixel clock and recovers per-pixel coordinates for the capture path. Measures line
//  and frame geometry and declares lock once geometry is stable over several frames.
//  Sits between the video input pins and the framebuffer write logic.
// PARAMETERS
//  HS_ACTIVE    1'b0   level of hsync during its pulse
//  VS_ACTIVE    1'b0   level of vsync during its pulse
//  LOCK_FRAMES  3      consecutive identical frames required for lock (1..15)
//  H_TIMEOUT    4095   clocks with no hsync leading edge before dropping to SEARCH
// PORTS
//  xclk         in   1   pixel clock, all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  hsync_in     in   1   horizontal sync, polarity per HS_ACTIVE
//  vsync_in     in   1   vertical sync, polarity per VS_ACTIVE
//  de_in        in   1   data enable, high during active pixels
//  pix_valid    out  1   registered de; qualifies pix_x/pix_y
//  pix_x        out  11  column of current active pixel, 0-based
//  pix_y        out  11  row of current active pixel, 0-based
//  line_start   out  1   1-cycle pulse with first pixel of each active line
//  frame_start  out  1   1-cycle pulse with pixel (0,0) of each frame
//  h_total      out  12  clocks between hsync leading edges (last completed frame)
//  h_active     out  12  de-high clocks in last active line
//  v_total      out  12  hsync leading edges per frame
//  v_active     out  12  de lines per frame
//  locked       out  1   geometry stable for LOCK_FRAMES frames
//  fmt_change   out  1   1-cycle pulse when a locked geometry changes
// BEHAVIOUR
//  - Inputs pass one register stage (s_hs, s_vs, s_de); edges are detected on that stage
//    against a second delayed copy. Leading edge = transition into the ACTIVE level.
//  - Latency: pix_valid/pix_x/pix_y/line_start/frame_start lag de_in by exactly 2 clocks.
//  - pix_x: 0 at de rising edge, +1 each de-high clock, held when de low.
//  - pix_y: set to 0 on first de rise after a vsync leading edge, else +1 on each de rise.
//    frame_start = line_start AND that first-line condition.
//  - pix_x/pix_y saturate at 2047; measurement counters saturate at 4095 (no wrap).
//  - Working counters: hcnt (clocks since hsync edge), decnt (de-high clocks in line),
//    lcnt (hsync edges since vsync edge), alcnt (de rises since vsync edge).
//  - On hsync leading edge: h_total_w <= hcnt+1, hcnt <= 0. On de falling edge: h_active_w <= decnt.
//  - On vsync leading edge: the frame's 4 values are compared with the previous frame's,
//    then published to h_total/h_active/v_total/v_active the same cycle; lcnt, alcnt clear.
//  - If vsync and hsync leading edges coincide, hsync is processed first (counted in frame).
//  - FSM states:
//    SEARCH : locked=0; wait vsync leading edge -> MEASURE, match count mc <= 0.
//    MEASURE: per frame, match -> mc+1 else mc <= 0; mc reaches LOCK_FRAMES-1 on a match
//             -> LOCKED, locked=1 from the next cycle.
//    LOCKED : match -> stay; mismatch -> MEASURE, locked=0, fmt_change pulse, mc <= 0.
//    any    : hcnt reaches H_TIMEOUT -> SEARCH; all four outputs cleared to 0,
//             no fmt_change pulse.
//  - The first frame after SEARCH has no predecessor: it is a mismatch, mc stays 0.
//  - Reset: all outputs 0, state SEARCH, all counters and shadow values 0.
//  - Reset mid-frame: the partial frame is discarded; pix_valid drops the next cycle.
// TESTING
//  1 Feed 844-clk lines, 640 de clks, 1067 lines/frame, 1024 de lines, active-low syncs
//    -> after frame 1 h_total=844 h_active=640 v_total=1067 v_active=1024;
//    locked rises after the 3rd identical frame boundary.
//  2 Locked, then change line to 900 clks -> at the next vsync edge fmt_change 1 clk,
//    locked=0, h_total=900; relock after 3 frames.
//  3 Check pix_x 0..639 and pix_y 0..1023 against de_in delayed 2 clks;
//    frame_start exactly once per frame, at (0,0).
//  4 Stop hsync for 4095 clks -> state SEARCH, locked=0, measurements 0; resume -> relock.
//  5 Assert rst mid-line for 1 clk -> all outputs 0 next cycle;
//    pix_y restarts at 0 after the next vsync.
//  6 Place a vsync edge on the same clock as an hsync edge -> v_total counts that line,
//    no lock loss.

Source files
------------

// File: rtl/vga_timing_rx_if.sv
// Video input bundle between the sync source (pins) and the timing receiver.
// master drives syncs/de, slave recovers coordinates and geometry.
interface vga_timing_rx_if;
   logic        hsync_in;
   logic        vsync_in;
   logic        de_in;
   logic        pix_valid;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic        line_start;
   logic        frame_start;
   logic [11:0] h_total;
   logic [11:0] h_active;
   logic [11:0] v_total;
   logic [11:0] v_active;
   logic        locked;
   logic        fmt_change;

   modport master (
      output hsync_in, vsync_in, de_in,
      input  pix_valid, pix_x, pix_y, line_start, frame_start,
      input  h_total, h_active, v_total, v_active, locked, fmt_change
   );

   modport slave (
      input  hsync_in, vsync_in, de_in,
      output pix_valid, pix_x, pix_y, line_start, frame_start,
      output h_total, h_active, v_total, v_active, locked, fmt_change
   );
endinterface

// File: rtl/vga_timing_rx.sv
// Receive-side video timing recovery: pixel coordinates, line/frame geometry
// measurement and lock detection from incoming hsync/vsync/de.
//
// state   | meaning
// SEARCH  | no usable timing; waiting for a vsync leading edge
// MEASURE | counting consecutive frames with identical geometry
// LOCKED  | geometry stable; a differing frame pulses fmt_change
module vga_timing_rx #(
   parameter logic        HS_ACTIVE   = 1'b0,
   parameter logic        VS_ACTIVE   = 1'b0,
   parameter int unsigned LOCK_FRAMES = 3,
   parameter int unsigned H_TIMEOUT   = 4095
) (
   input logic           xclk,
   input logic           rst,
   vga_timing_rx_if.slave vid
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   localparam logic [11:0] TO_LIM = 12'(H_TIMEOUT);
   localparam logic [4:0]  LF_M1  = 5'(LOCK_FRAMES - 1);

   function automatic logic [11:0] sat12(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   function automatic logic [10:0] sat11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  mc_q, mc_d;
   logic        pv_q, pv_d;

   logic        s_hs_q, s_vs_q, s_de_q;
   logic        d_hs_q, d_vs_q, d_de_q;
   logic        hs_lead, vs_lead, de_rise, de_fall;

   logic [11:0] hcnt_q, hcnt_d;
   logic [11:0] decnt_q, decnt_d;
   logic [11:0] lcnt_q, lcnt_d, lcnt_fr;
   logic [11:0] alcnt_q, alcnt_d, alcnt_fr;
   logic [11:0] h_total_w_q, h_total_w_d;
   logic [11:0] h_active_w_q, h_active_w_d;

   logic [11:0] h_total_q, h_total_d;
   logic [11:0] h_active_q, h_active_d;
   logic [11:0] v_total_q, v_total_d;
   logic [11:0] v_active_q, v_active_d;
   logic        fmt_change_q, fmt_change_d;

   logic        pix_valid_q, pix_valid_d;
   logic [10:0] pix_x_q, pix_x_d;
   logic [10:0] pix_y_q, pix_y_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   logic        fl_q, fl_d;
   logic        first_line;

   logic        timeout;
   logic        geom_match;
   logic        lock_hit;

   assign hs_lead = (s_hs_q == HS_ACTIVE) && (d_hs_q != HS_ACTIVE);
   assign vs_lead = (s_vs_q == VS_ACTIVE) && (d_vs_q != VS_ACTIVE);
   assign de_rise = s_de_q && !d_de_q;
   assign de_fall = !s_de_q && d_de_q;

   // Working counters; *_fr values include an hsync/de event in this very
   // cycle so a coincident vsync edge publishes them as part of the frame.
   always_comb begin
      hcnt_d       = hs_lead ? 12'd0 : sat12(hcnt_q);
      h_total_w_d  = hs_lead ? sat12(hcnt_q) : h_total_w_q;
      lcnt_fr      = hs_lead ? sat12(lcnt_q) : lcnt_q;
      alcnt_fr     = de_rise ? sat12(alcnt_q) : alcnt_q;
      decnt_d      = decnt_q;
      if (de_rise) begin
         decnt_d = 12'd1;
      end else if (s_de_q) begin
         decnt_d = sat12(decnt_q);
      end
      h_active_w_d = de_fall ? decnt_q : h_active_w_q;
      lcnt_d       = vs_lead ? 12'd0 : lcnt_fr;
      alcnt_d      = vs_lead ? 12'd0 : alcnt_fr;
   end

   assign timeout    = (hcnt_q >= TO_LIM);
   assign geom_match = pv_q
                       && (h_total_w_d  == h_total_q)
                       && (h_active_w_d == h_active_q)
                       && (lcnt_fr      == v_total_q)
                       && (alcnt_fr     == v_active_q);
   assign lock_hit   = ({1'b0, mc_q} + 5'd1) >= LF_M1;

   always_comb begin
      state_d      = state_q;
      mc_d         = mc_q;
      pv_d         = pv_q;
      fmt_change_d = 1'b0;
      h_total_d    = h_total_q;
      h_active_d   = h_active_q;
      v_total_d    = v_total_q;
      v_active_d   = v_active_q;
      if (timeout) begin
         state_d    = SEARCH;
         mc_d       = 4'd0;
         pv_d       = 1'b0;
         h_total_d  = 12'd0;
         h_active_d = 12'd0;
         v_total_d  = 12'd0;
         v_active_d = 12'd0;
      end else if (vs_lead) begin
         h_total_d  = h_total_w_d;
         h_active_d = h_active_w_d;
         v_total_d  = lcnt_fr;
         v_active_d = alcnt_fr;
         pv_d       = 1'b1;
         case (state_q)
            SEARCH: begin
               // The frame ending here began during search and is not a reference.
               state_d = MEASURE;
               mc_d    = 4'd0;
               pv_d    = 1'b0;
            end
            MEASURE: begin
               if (geom_match) begin
                  mc_d = mc_q + 4'd1;
                  if (lock_hit) begin
                     state_d = LOCKED;
                  end
               end else begin
                  mc_d = 4'd0;
               end
            end
            LOCKED: begin
               if (!geom_match) begin
                  state_d      = MEASURE;
                  mc_d         = 4'd0;
                  fmt_change_d = 1'b1;
               end
            end
            default: begin
               state_d = SEARCH;
               mc_d    = 4'd0;
               pv_d    = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      first_line    = fl_q || vs_lead;
      pix_valid_d   = s_de_q;
      line_start_d  = de_rise;
      frame_start_d = de_rise && first_line;
      fl_d          = de_rise ? 1'b0 : first_line;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      if (de_rise) begin
         pix_x_d = 11'd0;
         pix_y_d = first_line ? 11'd0 : sat11(pix_y_q);
      end else if (s_de_q) begin
         pix_x_d = sat11(pix_x_q);
      end
   end

   always_ff @(posedge xclk) begin
      if (rst) begin
         state_q <= SEARCH;
         mc_q    <= 4'd0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mc_q    <= mc_d;
         pv_q    <= pv_d;
      end
   end

   // Sync stages reset to the inactive level so release of reset is not an edge.
   always_ff @(posedge xclk) begin
      if (rst) begin
         s_hs_q        <= ~HS_ACTIVE;
         s_vs_q        <= ~VS_ACTIVE;
         s_de_q        <= 1'b0;
         d_hs_q        <= ~HS_ACTIVE;
         d_vs_q        <= ~VS_ACTIVE;
         d_de_q        <= 1'b0;
         hcnt_q        <= 12'd0;
         decnt_q       <= 12'd0;
         lcnt_q        <= 12'd0;
         alcnt_q       <= 12'd0;
         h_total_w_q   <= 12'd0;
         h_active_w_q  <= 12'd0;
         h_total_q     <= 12'd0;
         h_active_q    <= 12'd0;
         v_total_q     <= 12'd0;
         v_active_q    <= 12'd0;
         fmt_change_q  <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= 11'd0;
         pix_y_q       <= 11'd0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         fl_q          <= 1'b0;
      end else begin
         s_hs_q        <= vid.hsync_in;
         s_vs_q        <= vid.vsync_in;
         s_de_q        <= vid.de_in;
         d_hs_q        <= s_hs_q;
         d_vs_q        <= s_vs_q;
         d_de_q        <= s_de_q;
         hcnt_q        <= hcnt_d;
         decnt_q       <= decnt_d;
         lcnt_q        <= lcnt_d;
         alcnt_q       <= alcnt_d;
         h_total_w_q   <= h_total_w_d;
         h_active_w_q  <= h_active_w_d;
         h_total_q     <= h_total_d;
         h_active_q    <= h_active_d;
         v_total_q     <= v_total_d;
         v_active_q    <= v_active_d;
         fmt_change_q  <= fmt_change_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         fl_q          <= fl_d;
      end
   end

   assign vid.pix_valid   = pix_valid_q;
   assign vid.pix_x       = pix_x_q;
   assign vid.pix_y       = pix_y_q;
   assign vid.line_start  = line_start_q;
   assign vid.frame_start = frame_start_q;
   assign vid.h_total     = h_total_q;
   assign vid.h_active    = h_active_q;
   assign vid.v_total     = v_total_q;
   assign vid.v_active    = v_active_q;
   assign vid.locked      = (state_q == LOCKED);
   assign vid.fmt_change  = fmt_change_q;

endmodule
